bulls_cows_engine: RTL and testbench

Parametrised two-player Bulls & Cows game controller, the next generation of the board's game core. It accepts each player's secret from the switches, validates every submitted code (BCD-only, no repeated digits), scores guesses with a sequential pair-scan engine, tracks per-player attempt counts and declares a win or a draw. Results leave as raw bulls/cows counts plus phase and player codes; display-glyph mapping happens in a separate decoder downstream.

---
 rtl/bulls_cows_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_bulls_cows_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bulls_cows_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bulls_cows_engine : two-player Bulls & Cows controller with code          |
// | validation, sequential pair-scan scoring and win/draw detection.          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module bulls_cows_engine #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 8,
    parameter int BC_W      = $clog2(DIGITS + 1),
    parameter int TRY_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [4*DIGITS-1:0] sw_i,
    input  logic                enter_i,
    output logic [2:0]          phase_o,
    output logic                player_o,
    output logic [BC_W-1:0]     bulls_o,
    output logic [BC_W-1:0]     cows_o,
    output logic [TRY_W-1:0]    tries1_o,
    output logic [TRY_W-1:0]    tries2_o,
    output logic                invalid_o,
    output logic                busy_o,
    output logic                p1_win_o,
    output logic                p2_win_o,
    output logic                draw_o
);
    localparam logic [2:0] S_SET1   = 3'd0;
    localparam logic [2:0] S_SET2   = 3'd1;
    localparam logic [2:0] S_GUESS  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SCORE  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;
    localparam logic [2:0] S_WIN    = 3'd6;
    localparam logic [2:0] S_DRAW   = 3'd7;

    localparam int               IDX_W     = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  ALL_BULLS = BC_W'(DIGITS);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_SAT   = {TRY_W{1'b1}};
    localparam bit               LIMITED   = (MAX_TRIES != 0);

    logic [2:0]          phase_q, phase_d;
    logic [2:0]          origin_q, origin_d;
    logic                player_q, player_d;
    logic [BC_W-1:0]     bulls_q, bulls_d;
    logic [BC_W-1:0]     cows_q, cows_d;
    logic [TRY_W-1:0]    tries1_q, tries1_d;
    logic [TRY_W-1:0]    tries2_q, tries2_d;
    logic                invalid_q, invalid_d;
    logic [4*DIGITS-1:0] secret1_q, secret1_d;
    logic [4*DIGITS-1:0] secret2_q, secret2_d;
    logic [4*DIGITS-1:0] cand_q, cand_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic                done_q, done_d;
    logic                bad_q, bad_d;
    logic                enter_q;

    logic                busy;
    logic                rise;
    logic [3:0]          dig_i, dig_j, sec_j;
    logic [4*DIGITS-1:0] target;
    logic                other_full;

    assign busy   = (phase_q == S_CHECK) || (phase_q == S_SCORE);
    assign rise   = enter_i & ~enter_q & ~busy;
    // P1 attacks P2's secret and vice versa.
    assign target = player_q ? secret1_q : secret2_q;
    assign dig_i  = cand_q[4*i_q +: 4];
    assign dig_j  = cand_q[4*j_q +: 4];
    assign sec_j  = target[4*j_q +: 4];
    assign other_full = LIMITED && ((player_q ? tries1_q : tries2_q) == TRY_LIMIT);

    always_comb begin
        phase_d   = phase_q;
        origin_d  = origin_q;
        player_d  = player_q;
        bulls_d   = bulls_q;
        cows_d    = cows_q;
        tries1_d  = tries1_q;
        tries2_d  = tries2_q;
        invalid_d = invalid_q;
        secret1_d = secret1_q;
        secret2_d = secret2_q;
        cand_d    = cand_q;
        i_d       = i_q;
        j_d       = j_q;
        done_d    = done_q;
        bad_d     = bad_q;

        // Shared pair walker for CHECK and SCORE; done marks the decide cycle.
        if (busy && !done_q) begin
            if (j_q == LAST_IDX) begin
                j_d = '0;
                if (i_q == LAST_IDX) begin
                    done_d = 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end

        case (phase_q)
            S_SET1, S_SET2, S_GUESS: begin
                if (rise) begin
                    cand_d   = sw_i;
                    origin_d = phase_q;
                    phase_d  = S_CHECK;
                    i_d      = '0;
                    j_d      = '0;
                    done_d   = 1'b0;
                    bad_d    = 1'b0;
                end
            end
            S_CHECK: begin
                if (!done_q) begin
                    if ((dig_i > 4'd9) || ((i_q != j_q) && (dig_i == dig_j))) begin
                        bad_d = 1'b1;
                    end
                end else if (bad_q) begin
                    invalid_d = 1'b1;
                    phase_d   = origin_q;
                end else begin
                    invalid_d = 1'b0;
                    case (origin_q)
                        S_SET1: begin
                            secret1_d = cand_q;
                            phase_d   = S_SET2;
                        end
                        S_SET2: begin
                            secret2_d = cand_q;
                            player_d  = 1'b0;
                            phase_d   = S_GUESS;
                        end
                        default: begin
                            phase_d = S_SCORE;
                            bulls_d = '0;
                            cows_d  = '0;
                            i_d     = '0;
                            j_d     = '0;
                            done_d  = 1'b0;
                            if (!player_q) begin
                                if (tries1_q != TRY_SAT) tries1_d = tries1_q + 1'b1;
                            end else begin
                                if (tries2_q != TRY_SAT) tries2_d = tries2_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_SCORE: begin
                if (!done_q) begin
                    if (dig_i == sec_j) begin
                        if (i_q == j_q) bulls_d = bulls_q + 1'b1;
                        else            cows_d  = cows_q + 1'b1;
                    end
                end else begin
                    phase_d = (bulls_q == ALL_BULLS) ? S_WIN : S_RESULT;
                end
            end
            S_RESULT: begin
                if (rise) begin
                    if (LIMITED && (tries1_q == TRY_LIMIT) && (tries2_q == TRY_LIMIT)) begin
                        phase_d = S_DRAW;
                    end else begin
                        phase_d = S_GUESS;
                        if (!other_full) player_d = ~player_q;
                    end
                end
            end
            default: begin
                if (rise) begin
                    phase_d   = S_SET1;
                    secret1_d = '0;
                    secret2_d = '0;
                    tries1_d  = '0;
                    tries2_d  = '0;
                    bulls_d   = '0;
                    cows_d    = '0;
                    invalid_d = 1'b0;
                    player_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q   <= S_SET1;
            origin_q  <= S_SET1;
            player_q  <= 1'b0;
            bulls_q   <= '0;
            cows_q    <= '0;
            tries1_q  <= '0;
            tries2_q  <= '0;
            invalid_q <= 1'b0;
            secret1_q <= '0;
            secret2_q <= '0;
            cand_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            done_q    <= 1'b0;
            bad_q     <= 1'b0;
            enter_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            origin_q  <= origin_d;
            player_q  <= player_d;
            bulls_q   <= bulls_d;
            cows_q    <= cows_d;
            tries1_q  <= tries1_d;
            tries2_q  <= tries2_d;
            invalid_q <= invalid_d;
            secret1_q <= secret1_d;
            secret2_q <= secret2_d;
            cand_q    <= cand_d;
            i_q       <= i_d;
            j_q       <= j_d;
            done_q    <= done_d;
            bad_q     <= bad_d;
            enter_q   <= enter_i;
        end
    end

    assign phase_o   = phase_q;
    assign player_o  = player_q;
    assign bulls_o   = bulls_q;
    assign cows_o    = cows_q;
    assign tries1_o  = tries1_q;
    assign tries2_o  = tries2_q;
    assign invalid_o = invalid_q;
    assign busy_o    = busy;
    assign p1_win_o  = (phase_q == S_WIN) && !player_q;
    assign p2_win_o  = (phase_q == S_WIN) && player_q;
    assign draw_o    = (phase_q == S_DRAW);

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_engine.sv
`default_nettype none
// Scoreboard bench for bulls_cows_engine: DIGITS=4/MAX_TRIES=2 and DIGITS=6 instances.
module tb_bulls_cows_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] sw4 = '0;
    logic        en4 = 1'b0;
    logic [2:0]  phase4, bulls4, cows4;
    logic        player4, inv4, busy4, p1w4, p2w4, draw4;
    logic [7:0]  t1_4, t2_4;

    logic [23:0] sw6 = '0;
    logic        en6 = 1'b0;
    logic [2:0]  phase6, bulls6, cows6;
    logic        player6, inv6, busy6, p1w6, p2w6, draw6;
    logic [7:0]  t1_6, t2_6;

    bulls_cows_engine #(.DIGITS(4), .MAX_TRIES(2)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .sw_i(sw4), .enter_i(en4),
        .phase_o(phase4), .player_o(player4), .bulls_o(bulls4), .cows_o(cows4),
        .tries1_o(t1_4), .tries2_o(t2_4), .invalid_o(inv4), .busy_o(busy4),
        .p1_win_o(p1w4), .p2_win_o(p2w4), .draw_o(draw4)
    );

    bulls_cows_engine #(.DIGITS(6), .MAX_TRIES(8)) u_dut6 (
        .clk_i(clk), .rst_ni(rst_n), .sw_i(sw6), .enter_i(en6),
        .phase_o(phase6), .player_o(player6), .bulls_o(bulls6), .cows_o(cows6),
        .tries1_o(t1_6), .tries2_o(t2_6), .invalid_o(inv6), .busy_o(busy6),
        .p1_win_o(p1w6), .p2_win_o(p2w6), .draw_o(draw6)
    );

    typedef struct {int b; int c;} exp_t;
    exp_t sb[$];
    int vec  = 0;
    int errs = 0;

    function automatic void score_model(input logic [23:0] g, input logic [23:0] s,
                                        input int n, output int b, output int c);
        b = 0;
        c = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (g[4*i +: 4] == s[4*j +: 4]) begin
                    if (i == j) b++;
                    else        c++;
                end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en4 = 1'b0; en6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input bit d6, input logic [23:0] v);
        @(negedge clk);
        if (d6) begin sw6 = v; en6 = 1'b1; end
        else    begin sw4 = v[15:0]; en4 = 1'b1; end
        @(negedge clk);
        en4 = 1'b0; en6 = 1'b0;
    endtask

    task automatic wait_idle(input bit d6);
        int n;
        n = 0;
        while ((d6 ? busy6 : busy4) === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (n >= 200) begin
            errs++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
        end
    endtask

    // Pushes the model score, holds enter high and counts edges until RESULT/WIN.
    task automatic run_guess(input bit d6, input logic [23:0] v, input logic [23:0] sec,
                             output int lat);
        int   b, c;
        exp_t e;
        logic [2:0] ph;
        score_model(v, sec, d6 ? 6 : 4, b, c);
        e.b = b; e.c = c;
        sb.push_back(e);
        @(negedge clk);
        if (d6) begin sw6 = v; en6 = 1'b1; end
        else    begin sw4 = v[15:0]; en4 = 1'b1; end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            ph = d6 ? phase6 : phase4;
        end while (ph != 3'd5 && ph != 3'd6 && lat < 300);
        @(negedge clk);
        en4 = 1'b0; en6 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vec++; if (phase4 !== 3'd0 || phase6 !== 3'd0) begin errs++; $display("FAIL reset_phase: got %0d/%0d, required 0", phase4, phase6); end
        vec++; if ({player4, bulls4, cows4, inv4, busy4} !== 9'd0) begin errs++; $display("FAIL reset_regs: got %b, required 0", {player4, bulls4, cows4, inv4, busy4}); end
        vec++; if (t1_4 !== 8'd0 || t2_4 !== 8'd0) begin errs++; $display("FAIL reset_tries: got %0d/%0d, required 0/0", t1_4, t2_4); end
        vec++; if ({p1w4, p2w4, draw4} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b, required 000", {p1w4, p2w4, draw4}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec++; if (phase4 !== 3'd0 || busy4 !== 1'b0) begin errs++; $display("FAIL reset_idle: phase %0d busy %0d, required 0/0", phase4, busy4); end
    endtask

    task automatic test_invalid_secret();
        do_reset();
        pulse(0, 24'h1123); wait_idle(0);
        vec++; if (phase4 !== 3'd0 || inv4 !== 1'b1) begin errs++; $display("FAIL inv_repeat: phase %0d invalid %0d, required 0/1", phase4, inv4); end
        pulse(0, 24'h1A23); wait_idle(0);
        vec++; if (phase4 !== 3'd0 || inv4 !== 1'b1) begin errs++; $display("FAIL inv_nonbcd: phase %0d invalid %0d, required 0/1", phase4, inv4); end
        pulse(0, 24'h1023); wait_idle(0);
        vec++; if (phase4 !== 3'd1 || inv4 !== 1'b0) begin errs++; $display("FAIL inv_accept: phase %0d invalid %0d, required 1/0", phase4, inv4); end
    endtask

    task automatic test_score_p1();
        int   lat;
        exp_t e;
        do_reset();
        pulse(0, 24'h1234); wait_idle(0);
        pulse(0, 24'h5678); wait_idle(0);
        vec++; if (phase4 !== 3'd2 || player4 !== 1'b0) begin errs++; $display("FAIL setup_guess: phase %0d player %0d, required 2/0", phase4, player4); end
        run_guess(0, 24'h8765, 24'h5678, lat);
        vec++; if (lat !== 35) begin errs++; $display("FAIL p1_latency: got %0d cycles, required 35", lat); end
        vec++; if (phase4 !== 3'd5) begin errs++; $display("FAIL p1_phase: got %0d, required 5", phase4); end
        e = sb.pop_front();
        vec++; if (int'(bulls4) !== e.b || int'(cows4) !== e.c) begin errs++; $display("FAIL p1_score: got %0d/%0d, required %0d/%0d", bulls4, cows4, e.b, e.c); end
        vec++; if (t1_4 !== 8'd1 || t2_4 !== 8'd0 || player4 !== 1'b0) begin errs++; $display("FAIL p1_tries: got %0d/%0d player %0d, required 1/0 player 0", t1_4, t2_4, player4); end
        repeat (4) @(negedge clk);
        vec++; if (int'(bulls4) !== e.b || int'(cows4) !== e.c || phase4 !== 3'd5) begin errs++; $display("FAIL result_hold: got %0d/%0d phase %0d, required %0d/%0d phase 5", bulls4, cows4, phase4, e.b, e.c); end
    endtask

    task automatic test_p2_win();
        int   lat;
        exp_t e;
        pulse(0, 24'h0);
        vec++; if (phase4 !== 3'd2 || player4 !== 1'b1) begin errs++; $display("FAIL p2_turn: phase %0d player %0d, required 2/1", phase4, player4); end
        run_guess(0, 24'h1234, 24'h1234, lat);
        vec++; if (phase4 !== 3'd6 || lat !== 35) begin errs++; $display("FAIL p2_win_phase: phase %0d lat %0d, required 6/35", phase4, lat); end
        e = sb.pop_front();
        vec++; if (int'(bulls4) !== e.b || int'(cows4) !== e.c) begin errs++; $display("FAIL p2_score: got %0d/%0d, required %0d/%0d", bulls4, cows4, e.b, e.c); end
        vec++; if (p2w4 !== 1'b1 || p1w4 !== 1'b0 || t2_4 !== 8'd1) begin errs++; $display("FAIL p2_flags: p2 %0d p1 %0d tries2 %0d, required 1/0/1", p2w4, p1w4, t2_4); end
        repeat (5) @(negedge clk);
        vec++; if (p2w4 !== 1'b1 || int'(bulls4) !== e.b) begin errs++; $display("FAIL win_hold: p2 %0d bulls %0d, required 1/%0d", p2w4, bulls4, e.b); end
        pulse(0, 24'h0);
        vec++; if (phase4 !== 3'd0 || {t1_4, t2_4} !== 16'd0 || {bulls4, cows4, player4, inv4, p2w4} !== 9'd0) begin
            errs++; $display("FAIL win_restart: phase %0d tries %0d/%0d bulls %0d cows %0d player %0d, required all 0", phase4, t1_4, t2_4, bulls4, cows4, player4);
        end
    endtask

    task automatic test_draw();
        logic [15:0] g [4] = '{16'h0123, 16'h4567, 16'h9012, 16'h4321};
        logic [15:0] sec;
        int   lat;
        exp_t e;
        do_reset();
        pulse(0, 24'h1234); wait_idle(0);
        pulse(0, 24'h5678); wait_idle(0);
        pulse(0, 24'h1111); wait_idle(0);
        vec++; if (phase4 !== 3'd2 || inv4 !== 1'b1 || t1_4 !== 8'd0) begin errs++; $display("FAIL bad_guess: phase %0d invalid %0d tries1 %0d, required 2/1/0", phase4, inv4, t1_4); end
        for (int k = 0; k < 4; k++) begin
            sec = (k % 2 == 0) ? 16'h5678 : 16'h1234;
            run_guess(0, {8'h0, g[k]}, {8'h0, sec}, lat);
            e = sb.pop_front();
            vec++; if (int'(bulls4) !== e.b || int'(cows4) !== e.c || inv4 !== 1'b0) begin errs++; $display("FAIL draw_score%0d: got %0d/%0d inv %0d, required %0d/%0d inv 0", k, bulls4, cows4, inv4, e.b, e.c); end
            vec++; if (int'(t1_4) !== (k + 2) / 2 || int'(t2_4) !== (k + 1) / 2) begin errs++; $display("FAIL draw_tries%0d: got %0d/%0d, required %0d/%0d", k, t1_4, t2_4, (k + 2) / 2, (k + 1) / 2); end
            pulse(0, 24'h0);
            if (k < 3) begin
                vec++; if (phase4 !== 3'd2 || int'(player4) !== (k + 1) % 2) begin errs++; $display("FAIL draw_turn%0d: phase %0d player %0d, required 2/%0d", k, phase4, player4, (k + 1) % 2); end
            end else begin
                vec++; if (phase4 !== 3'd7 || draw4 !== 1'b1 || p1w4 !== 1'b0 || p2w4 !== 1'b0) begin errs++; $display("FAIL draw_state: phase %0d draw %0d, required 7/1", phase4, draw4); end
            end
        end
        pulse(0, 24'h0);
        vec++; if (phase4 !== 3'd0 || draw4 !== 1'b0 || t1_4 !== 8'd0) begin errs++; $display("FAIL draw_restart: phase %0d draw %0d tries1 %0d, required 0/0/0", phase4, draw4, t1_4); end
    endtask

    task automatic test_back_to_back();
        int   n, b, c;
        exp_t e;
        do_reset();
        pulse(0, 24'h1234); wait_idle(0);
        pulse(0, 24'h5678); wait_idle(0);
        score_model(24'h7856, 24'h5678, 4, b, c);
        e.b = b; e.c = c;
        sb.push_back(e);
        @(negedge clk);
        sw4 = 16'h7856; en4 = 1'b1;
        n = 0;
        while (phase4 !== 3'd5 && phase4 !== 3'd6 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 10 || n == 20) en4 = 1'b0;
            if (n == 11 || n == 21) en4 = 1'b1;
        end
        repeat (5) @(negedge clk);
        e = sb.pop_front();
        vec++; if (phase4 !== 3'd5 || t1_4 !== 8'd1 || t2_4 !== 8'd0) begin errs++; $display("FAIL b2b_once: phase %0d tries %0d/%0d, required 5 and 1/0", phase4, t1_4, t2_4); end
        vec++; if (int'(bulls4) !== e.b || int'(cows4) !== e.c) begin errs++; $display("FAIL b2b_score: got %0d/%0d, required %0d/%0d", bulls4, cows4, e.b, e.c); end
        en4 = 1'b0;
    endtask

    task automatic test_reset_mid_score();
        do_reset();
        pulse(0, 24'h1234); wait_idle(0);
        pulse(0, 24'h5678); wait_idle(0);
        pulse(0, 24'h5678);
        repeat (22) @(posedge clk);
        #1;
        vec++; if (phase4 !== 3'd4 || t1_4 !== 8'd1 || busy4 !== 1'b1) begin errs++; $display("FAIL mid_score: phase %0d tries1 %0d busy %0d, required 4/1/1", phase4, t1_4, busy4); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if (phase4 !== 3'd0 || busy4 !== 1'b0 || t1_4 !== 8'd0) begin errs++; $display("FAIL abort_state: phase %0d busy %0d tries1 %0d, required 0/0/0", phase4, busy4, t1_4); end
        vec++; if ({bulls4, cows4, player4, inv4} !== 8'd0) begin errs++; $display("FAIL abort_regs: bulls %0d cows %0d, required 0/0", bulls4, cows4); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (phase4 !== 3'd0 || busy4 !== 1'b0) begin errs++; $display("FAIL abort_after: phase %0d busy %0d, required 0/0", phase4, busy4); end
    endtask

    task automatic test_digits6();
        int   lat;
        exp_t e;
        do_reset();
        pulse(1, 24'h987654); wait_idle(1);
        pulse(1, 24'h012345); wait_idle(1);
        vec++; if (phase6 !== 3'd2 || inv6 !== 1'b0) begin errs++; $display("FAIL d6_setup: phase %0d invalid %0d, required 2/0", phase6, inv6); end
        run_guess(1, 24'h012354, 24'h012345, lat);
        vec++; if (lat !== 75 || phase6 !== 3'd5) begin errs++; $display("FAIL d6_latency: lat %0d phase %0d, required 75/5", lat, phase6); end
        e = sb.pop_front();
        vec++; if (int'(bulls6) !== e.b || int'(cows6) !== e.c) begin errs++; $display("FAIL d6_score: got %0d/%0d, required %0d/%0d", bulls6, cows6, e.b, e.c); end
        vec++; if (t1_6 !== 8'd1 || {p1w6, p2w6, draw6} !== 3'b000) begin errs++; $display("FAIL d6_tries: tries1 %0d flags %b, required 1/000", t1_6, {p1w6, p2w6, draw6}); end
    endtask

    initial begin
        test_reset();
        test_invalid_secret();
        test_score_p1();
        test_p2_win();
        test_draw();
        test_back_to_back();
        test_reset_mid_score();
        test_digits6();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
`default_nettype wire
